modmul_pipe_k: RTL and testbench

MODMUL_PIPE_K -- requirements
Module: modmul_pipe_K

---
 rtl/modmul_pipe_k.sv | 103 ++++++++++
 tb/tb_modmul_pipe_k.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/modmul_pipe_k.sv
// modmul_pipe_k: 3-stage pipelined modular multiplier, result = (a*b) mod 3329.
// S1 registers the operands, S2 the full 24-bit product, S3 the Barrett-reduced
// residue. A single stall (output valid but not taken) freezes the whole pipe.
module modmul_pipe_k #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [11:0]      a_i,
    input  logic [11:0]      b_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    output logic [11:0]      result_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic             err_o,
    output logic [CNT_W-1:0] cnt_o
);
    localparam logic [12:0] MODQ   = 13'd3329;
    localparam logic [35:0] BARR_M = 36'd5039;  // floor(2^24 / 3329)

    // Stage registers
    logic        s1_vld_q, s2_vld_q, s3_vld_q;
    logic [11:0] s1_a_q, s1_b_q;
    logic [23:0] s2_p_q;
    logic [11:0] s3_r_q;
    logic        err_q;
    logic [CNT_W-1:0] cnt_q;

    // Handshake
    logic stall, accept, xfer;
    assign stall       = s3_vld_q & ~out_ready_i;
    assign in_ready_o  = ~stall;
    assign accept      = in_valid_i & ~stall;
    assign xfer        = s3_vld_q & out_ready_i;

    assign result_o    = s3_r_q;
    assign out_valid_o = s3_vld_q;
    assign err_o       = err_q;
    assign cnt_o       = cnt_q;

    // Next-state values for the datapath
    logic [23:0] p_d;
    logic [35:0] qm;
    logic [11:0] q_est;
    logic [23:0] qq;
    logic [12:0] r_raw;
    logic [11:0] r_d;

    // Full-width product of the S1 operands
    always_comb begin
        p_d = {12'b0, s1_a_q} * {12'b0, s1_b_q};
    end

    // Barrett reduction of the S2 product with a single conditional correction;
    // for out-of-range operands the estimate may be off, which is acceptable.
    always_comb begin
        qm    = {12'b0, s2_p_q} * BARR_M;
        q_est = 12'(qm >> 24);
        qq    = {12'b0, q_est} * 24'd3329;
        r_raw = 13'(s2_p_q - qq);
        r_d   = (r_raw >= MODQ) ? 12'(r_raw - MODQ) : r_raw[11:0];
    end

    // Pipeline advance: all stages move together unless the output is stalled
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_vld_q <= 1'b0;
            s2_vld_q <= 1'b0;
            s3_vld_q <= 1'b0;
            s1_a_q   <= '0;
            s1_b_q   <= '0;
            s2_p_q   <= '0;
            s3_r_q   <= '0;
        end else if (!stall) begin
            s1_vld_q <= in_valid_i;
            s2_vld_q <= s1_vld_q;
            s3_vld_q <= s2_vld_q;
            if (accept) begin
                s1_a_q <= a_i;
                s1_b_q <= b_i;
            end
            if (s1_vld_q) s2_p_q <= p_d;
            if (s2_vld_q) s3_r_q <= r_d;
        end
    end

    // Sticky error on any accepted out-of-range operand
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            err_q <= 1'b0;
        else if (accept && ({1'b0, a_i} >= MODQ || {1'b0, b_i} >= MODQ))
            err_q <= 1'b1;
    end

    // Completed output transfer counter, wraps naturally
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            cnt_q <= '0;
        else if (xfer)
            cnt_q <= cnt_q + 1'b1;
    end
endmodule

// File: tb/tb_modmul_pipe_k.sv
// Directed + randomized bench for modmul_pipe_k. Inputs are driven and outputs
// sampled 1 time unit after each rising edge.
module tb_modmul_pipe_k;
    localparam int CW = 4;  // narrow counter so wrap-around is exercised

    logic          clk = 1'b0;
    logic          rst_n;
    logic [11:0]   a, b, res;
    logic          in_valid, in_ready, out_valid, out_ready, err;
    logic [CW-1:0] cnt;

    int checks = 0;
    int errors = 0;

    modmul_pipe_k #(.CNT_W(CW)) dut (
        .clk_i(clk), .rst_ni(rst_n), .a_i(a), .b_i(b),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .result_o(res), .out_valid_o(out_valid), .out_ready_i(out_ready),
        .err_o(err), .cnt_o(cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [11:0] aa, input logic [11:0] bb);
        in_valid = v;
        a = aa;
        b = bb;
    endtask

    initial begin
        int unsigned exp_q[$];
        int unsigned xfers;
        int unsigned ea;
        logic acc, xf;

        // ---------------- reset ----------------
        rst_n = 1'b0; drive(0, 0, 0); out_ready = 1'b1;
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_cnt", cnt, 0);
        chk("rst_err", err, 0);
        chk("rst_result", res, 0);
        step(); step();
        rst_n = 1'b1;

        // ---------------- single op 3328*3328 ----------------
        drive(1, 3328, 3328);
        step(); drive(0, 0, 0);          // accept edge
        chk("single_lat1", out_valid, 0);
        step();
        chk("single_lat2", out_valid, 0);
        step();                          // third edge counting the accept edge
        chk("single_valid", out_valid, 1);
        chk("single_result", res, 1);
        step();
        chk("single_cnt", cnt, 1);
        chk("single_drain", out_valid, 0);

        // ---------------- streaming ----------------
        drive(1, 2000, 2000); step();
        drive(1, 1234, 2);    step();
        drive(1, 0, 3328);    step();
        drive(0, 0, 0);
        chk("stream0_v", out_valid, 1); chk("stream0", res, 1871);
        step();
        chk("stream1_v", out_valid, 1); chk("stream1", res, 2468);
        step();
        chk("stream2_v", out_valid, 1); chk("stream2", res, 0);
        step();
        chk("stream_drain", out_valid, 0);
        chk("stream_cnt", cnt, 4);

        // ---------------- backpressure ----------------
        drive(1, 10, 20);    step();
        drive(1, 100, 100);  step();
        drive(1, 3000, 3000); step();
        out_ready = 1'b0;
        drive(1, 7, 11);                 // held by source until accepted
        #1;
        chk("bp_in_ready", in_ready, 0);
        chk("bp_head", res, 200);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_hold_v", out_valid, 1);
            chk("bp_hold_r", res, 200);
            chk("bp_hold_rdy", in_ready, 0);
        end
        chk("bp_cnt_frozen", cnt, 4);
        out_ready = 1'b1;
        #1;
        chk("bp_release_rdy", in_ready, 1);
        step(); drive(0, 0, 0);
        chk("bp_r1", res, 13);
        step();
        chk("bp_r2", res, 1713);
        step();
        chk("bp_r3", res, 77);
        chk("bp_r3_v", out_valid, 1);
        step();
        chk("bp_drain", out_valid, 0);
        chk("bp_cnt", cnt, 8);

        // ---------------- error flag ----------------
        drive(1, 4000, 1);
        #1;
        chk("err_before", err, 0);
        step();
        drive(1, 5, 5);
        chk("err_set", err, 1);
        step(); drive(0, 0, 0);
        chk("err_sticky1", err, 1);
        step();                          // 4000*1 result (unspecified value)
        chk("err_bad_v", out_valid, 1);
        step();
        chk("err_legal", res, 25);
        chk("err_sticky2", err, 1);
        step();
        chk("err_cnt", cnt, 10);

        // ---------------- reset mid-stream ----------------
        drive(1, 1, 1); step();
        drive(1, 2, 2); step();
        drive(1, 3, 3); step();
        drive(0, 0, 0);
        rst_n = 1'b0;
        #1;
        chk("mrst_v", out_valid, 0);
        chk("mrst_cnt", cnt, 0);
        chk("mrst_err", err, 0);
        chk("mrst_res", res, 0);
        chk("mrst_rdy", in_ready, 1);
        #2;
        rst_n = 1'b1;
        drive(1, 6, 7);                  // accepted on first edge after release
        step(); drive(0, 0, 0);
        chk("mrst_stale1", out_valid, 0);
        step();
        chk("mrst_stale2", out_valid, 0);
        step();
        chk("mrst_first_v", out_valid, 1);
        chk("mrst_first_r", res, 42);
        step();
        chk("mrst_quiet", out_valid, 0);
        chk("mrst_cnt1", cnt, 1);

        // ---------------- random stream with scoreboard ----------------
        xfers = 1;
        in_valid = 1'b0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (!(in_valid && !in_ready) || cyc == 0) begin
                in_valid = ($urandom_range(0, 3) != 0);
                a = 12'($urandom_range(0, 3328));
                b = 12'($urandom_range(0, 3328));
                if (cyc % 97 == 0) begin a = 12'd3328; b = 12'($urandom_range(3320, 3328)); end
            end
            #1;
            acc = in_valid && in_ready;
            xf  = out_valid && out_ready;
            ea  = (int'(a) * int'(b)) % 3329;
            if (xf) begin
                if (exp_q.size() == 0) chk("rand_spurious", 1, 0);
                else chk("rand_result", res, exp_q.pop_front());
                xfers++;
            end
            if (acc) exp_q.push_back(ea);
            @(posedge clk);
            #1;
        end
        drive(0, 0, 0);
        out_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            #1;
            if (out_valid) begin
                chk("drain_result", res, exp_q.pop_front());
                xfers++;
            end
            @(posedge clk);
            #1;
        end
        chk("drain_empty", exp_q.size(), 0);
        chk("rand_cnt_wrap", cnt, xfers % (1 << CW));
        chk("rand_err", err, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
